// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared encodings for the memory port arbiter.
// Holds arbiter state, owner ids and default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  typedef enum logic {
    ICACHE = 1'b0,
    DCACHE = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// rr_pick2: two-way picker between icache and dcache requests.
// Ties go to dcache in fixed mode, else to the non-last grantee.
module rr_pick2
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0
) (
  input  logic   req_i,
  input  logic   req_d,
  input  owner_t last_grant,
  output owner_t grant
);

  logic d_wins_tie;

  assign d_wins_tie = (FIXED_PRI != 0) ||
                      (last_grant == ICACHE);

  // Pick the owner; icache is the default when only it asks.
  always_comb begin
    grant = ICACHE;
    unique case (1'b1)
      (req_i && req_d):
        grant = d_wins_tie ? DCACHE : ICACHE;
      (req_d && !req_i):
        grant = DCACHE;
      default:
        grant = ICACHE;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between icache and dcache.
// Winner's command is latched; ready is routed to the owner only.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRI = 0,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_t state;
  owner_t last_grant;
  owner_t grant;
  logic   req_i;
  logic   req_d;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read || d_mem_write;

  rr_pick2 #(
    .FIXED_PRI (FIXED_PRI)
  ) u_pick (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;
  assign i_mem_ready = mem_ready && (state == BUSY_I);
  assign d_mem_ready = mem_ready && (state == BUSY_D);

  // Grant from IDLE, hold the latched command until memory completes.
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= ICACHE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_i || req_d) begin
            last_grant <= grant;
            if (grant == DCACHE) begin
              state     <= BUSY_D;
              mem_read  <= d_mem_read && !d_mem_write;
              mem_write <= d_mem_write;
              mem_addr  <= d_mem_addr;
              mem_wdata <= d_mem_wdata;
            end else begin
              state     <= BUSY_I;
              mem_read  <= 1'b1;
              mem_write <= 1'b0;
              mem_addr  <= i_mem_addr;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter.
// Instance 0 is round-robin, instance 1 fixed dcache priority.
module tb_mem_arbiter;

  typedef struct packed {
    logic         k;
    logic         rd;
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic k;
    logic i;
    logic d;
  } rdy_t;

  logic         clk;
  logic         proc_reset;
  logic         i_rd   [2];
  logic [27:0]  ia     [2];
  logic [127:0] i_rdat [2];
  logic         i_rdy  [2];
  logic         d_rd   [2];
  logic         d_wr   [2];
  logic [27:0]  da     [2];
  logic [127:0] dw     [2];
  logic [127:0] d_rdat [2];
  logic         d_rdy  [2];
  logic         m_rd   [2];
  logic         m_wr   [2];
  logic [27:0]  m_addr [2];
  logic [127:0] m_wd   [2];
  logic         mr     [2];
  logic [127:0] mem_rdata;

  cmd_t         cmd_q [$];
  rdy_t         rdy_q [$];
  logic [127:0] mdl_w [2];
  logic         prev_cmd [2];
  cmd_t         me;
  rdy_t         re;
  int           total;
  int           bad;

  mem_arbiter #(.FIXED_PRI(0)) u_rr (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_rd[0]),
    .i_mem_addr  (ia[0]),
    .i_mem_rdata (i_rdat[0]),
    .i_mem_ready (i_rdy[0]),
    .d_mem_read  (d_rd[0]),
    .d_mem_write (d_wr[0]),
    .d_mem_addr  (da[0]),
    .d_mem_wdata (dw[0]),
    .d_mem_rdata (d_rdat[0]),
    .d_mem_ready (d_rdy[0]),
    .mem_read    (m_rd[0]),
    .mem_write   (m_wr[0]),
    .mem_addr    (m_addr[0]),
    .mem_wdata   (m_wd[0]),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mr[0])
  );

  mem_arbiter #(.FIXED_PRI(1)) u_fp (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .i_mem_read  (i_rd[1]),
    .i_mem_addr  (ia[1]),
    .i_mem_rdata (i_rdat[1]),
    .i_mem_ready (i_rdy[1]),
    .d_mem_read  (d_rd[1]),
    .d_mem_write (d_wr[1]),
    .d_mem_addr  (da[1]),
    .d_mem_wdata (dw[1]),
    .d_mem_rdata (d_rdat[1]),
    .d_mem_ready (d_rdy[1]),
    .mem_read    (m_rd[1]),
    .mem_write   (m_wr[1]),
    .mem_addr    (m_addr[1]),
    .mem_wdata   (m_wd[1]),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chkw(string nm, logic [127:0] a,
                               logic [127:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endfunction

  function automatic void chkb(string nm, logic a, logic e);
    chkw(nm, {127'b0, a}, {127'b0, e});
  endfunction

  // Monitor: pop expected commands and ready strobes as they appear.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if ((m_rd[k] || m_wr[k]) && !prev_cmd[k]) begin
        if (cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL cmd_unexpected inst=%0d addr=%0h", k,
                   m_addr[k]);
        end else begin
          me = cmd_q.pop_front();
          chkb("cmd_inst", 1'(k), me.k);
          chkb("cmd_rd", m_rd[k], me.rd);
          chkb("cmd_wr", m_wr[k], me.wr);
          chkw("cmd_addr", {100'b0, m_addr[k]},
               {100'b0, me.addr});
          chkw("cmd_wdata", m_wd[k], me.wdata);
        end
      end
      prev_cmd[k] <= m_rd[k] || m_wr[k];
      if (mr[k]) begin
        if (rdy_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdy_unexpected inst=%0d", k);
        end else begin
          re = rdy_q.pop_front();
          chkb("rdy_inst", 1'(k), re.k);
          chkb("i_ready", i_rdy[k], re.i);
          chkb("d_ready", d_rdy[k], re.d);
          chkw("i_rdata", i_rdat[k], mem_rdata);
          chkw("d_rdata", d_rdat[k], mem_rdata);
        end
      end else if (i_rdy[k] || d_rdy[k]) begin
        total++;
        bad++;
        $display("FAIL stray_ready inst=%0d i=%0b d=%0b", k,
                 i_rdy[k], d_rdy[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    proc_reset = 1'b1;
    tick();
    tick();
    proc_reset = 1'b0;
    mdl_w[0] = '0;
    mdl_w[1] = '0;
  endtask

  task automatic exp_cmd(int k, bit is_d, logic rd, logic wr,
                         logic [27:0] a, logic [127:0] w);
    cmd_t e;
    e.k    = 1'(k);
    e.rd   = is_d ? (rd && !wr) : 1'b1;
    e.wr   = is_d ? wr : 1'b0;
    e.addr = a;
    if (is_d) mdl_w[k] = w;
    e.wdata = mdl_w[k];
    cmd_q.push_back(e);
  endtask

  task automatic pulse(int k, logic ei, logic ed, logic [127:0] rdat);
    rdy_t r;
    r.k = 1'(k);
    r.i = ei;
    r.d = ed;
    rdy_q.push_back(r);
    mem_rdata = rdat;
    mr[k] = 1'b1;
    tick();
    mr[k] = 1'b0;
  endtask

  task automatic done(int k, bit is_d, bit drop, logic [127:0] rdat);
    pulse(k, !is_d, is_d, rdat);
    if (drop) begin
      if (is_d) begin
        d_rd[k] = 1'b0;
        d_wr[k] = 1'b0;
      end else begin
        i_rd[k] = 1'b0;
      end
    end
  endtask

  task automatic tie(int k, bit d_first, logic [27:0] ai_,
                     logic [27:0] ad_, logic [127:0] w);
    i_rd[k] = 1'b1;
    ia[k]   = ai_;
    d_rd[k] = 1'b1;
    da[k]   = ad_;
    dw[k]   = w;
    if (d_first) begin
      exp_cmd(k, 1, 1, 0, ad_, w);
      exp_cmd(k, 0, 1, 0, ai_, '0);
    end else begin
      exp_cmd(k, 0, 1, 0, ai_, '0);
      exp_cmd(k, 1, 1, 0, ad_, w);
    end
    tick();
    tick();
    done(k, d_first, 1, 128'hA5A5);
    tick();
    tick();
    done(k, !d_first, 1, 128'h5A5A);
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    mem_rdata = '0;
    for (int k = 0; k < 2; k++) begin
      i_rd[k] = 0; ia[k] = '0; d_rd[k] = 0; d_wr[k] = 0;
      da[k] = '0; dw[k] = '0; mr[k] = 0; prev_cmd[k] = 0;
    end
    do_reset();
    for (int k = 0; k < 2; k++) begin
      chkb("rst_rd", m_rd[k], 1'b0);
      chkb("rst_wr", m_wr[k], 1'b0);
      chkw("rst_addr", {100'b0, m_addr[k]}, '0);
      chkw("rst_wdata", m_wd[k], '0);
    end
    pulse(0, 0, 0, 128'h77);
    chkb("idle_ready_no_cmd", m_rd[0], 1'b0);

    i_rd[0] = 1;
    ia[0] = 28'h0000010;
    exp_cmd(0, 0, 1, 0, 28'h0000010, '0);
    tick();
    chkb("i_latency", m_rd[0], 1'b1);
    ia[0] = 28'h0000777;
    tick();
    tick();
    chkw("i_addr_hold", {100'b0, m_addr[0]}, 128'h10);
    tick();
    done(0, 0, 1, 128'h1111_2222);
    chkb("i_cmd_clear", m_rd[0], 1'b0);

    d_wr[0] = 1;
    da[0] = 28'h00000A0;
    dw[0] = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
    exp_cmd(0, 1, 0, 1, 28'h00000A0, dw[0]);
    tick();
    chkb("d_wr_latency", m_wr[0], 1'b1);
    chkb("d_wr_no_rd", m_rd[0], 1'b0);
    tick();
    done(0, 1, 1, 128'h3333);
    chkb("d_cmd_clear", m_wr[0], 1'b0);

    i_rd[0] = 1;
    ia[0] = 28'h0000020;
    exp_cmd(0, 0, 1, 0, 28'h0000020, '0);
    tick();
    tick();
    done(0, 0, 1, 128'h4444);

    d_rd[0] = 1;
    d_wr[0] = 1;
    da[0] = 28'h00000C0;
    dw[0] = 128'h0BAD_F00D;
    exp_cmd(0, 1, 1, 1, 28'h00000C0, dw[0]);
    tick();
    tick();
    done(0, 1, 1, 128'h5555);

    tie(0, 0, 28'h0000030, 28'h00000D0, 128'h6666);
    do_reset();
    tie(0, 1, 28'h0000200, 28'h0000100, 128'h7777);
    tie(0, 1, 28'h0000400, 28'h0000300, 128'h8888);

    do_reset();
    d_wr[0] = 1;
    da[0] = 28'h00000B0;
    dw[0] = 128'h9999;
    exp_cmd(0, 1, 0, 1, 28'h00000B0, dw[0]);
    tick();
    tick();
    tick();
    proc_reset = 1;
    tick();
    chkb("rst_mid_wr", m_wr[0], 1'b0);
    chkb("rst_mid_rd", m_rd[0], 1'b0);
    proc_reset = 0;
    d_wr[0] = 0;
    mdl_w[0] = '0;
    mdl_w[1] = '0;
    tick();
    pulse(0, 0, 0, 128'hAAAA);
    i_rd[0] = 1;
    ia[0] = 28'h0000050;
    exp_cmd(0, 0, 1, 0, 28'h0000050, '0);
    tick();
    chkb("post_rst_latency", m_rd[0], 1'b1);
    done(0, 0, 1, 128'hBBBB);
    tick();

    do_reset();
    i_rd[1] = 1;
    ia[1] = 28'h0000040;
    d_rd[1] = 1;
    da[1] = 28'h0000050;
    dw[1] = 128'hC0C0;
    exp_cmd(1, 1, 1, 0, 28'h0000050, dw[1]);
    tick();
    tick();
    done(1, 1, 0, 128'h1);
    da[1] = 28'h0000051;
    exp_cmd(1, 1, 1, 0, 28'h0000051, dw[1]);
    tick();
    tick();
    done(1, 1, 0, 128'h2);
    da[1] = 28'h0000052;
    exp_cmd(1, 1, 1, 0, 28'h0000052, dw[1]);
    tick();
    tick();
    done(1, 1, 1, 128'h3);
    exp_cmd(1, 0, 1, 0, 28'h0000040, '0);
    tick();
    tick();
    done(1, 0, 1, 128'h4);
    tick();
    tick();

    chkw("cmd_q_empty", 128'(cmd_q.size()), '0);
    chkw("rdy_q_empty", 128'(rdy_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
